// File: rtl/cal_entry_seq.sv
// rtl/cal_entry_seq.sv - keypad entry sequencer building {a, b, op} for the ALU stage
// Optional backspace support is compiled in when CAL_BACKSPACE_EN is defined.
module cal_entry_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       op,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENTER_A = 2'd1;
  localparam logic [1:0] ENTER_B = 2'd2;
  localparam logic [1:0] ISSUE   = 2'd3;

  localparam logic [4:0] KEY_EQ   = 5'h13;
  localparam logic [4:0] KEY_CLR  = 5'h14;

  localparam int AW = WIDTH + 4;

  logic [1:0]    state;
  logic [3:0]    bcnt;
  logic          key_fire;
  logic          is_digit;
  logic          is_opkey;
  logic          is_eq;
  logic          is_clr;
  logic [1:0]    key_op;
  logic [AW-1:0] acc_base;
  logic [AW-1:0] acc_new;
  logic          acc_ovf;

  assign key_ready = (state != ISSUE);
  assign key_fire  = key_valid & key_ready;

  always_comb begin
    is_digit = (key_code[4] == 1'b0) && (key_code[3:0] <= 4'd9);
    is_opkey = (key_code[4] == 1'b1) && (key_code[3:0] <= 4'd2);
    is_eq    = (key_code == KEY_EQ);
    is_clr   = (key_code == KEY_CLR);
    key_op   = key_code[1:0];
  end

  // Shared decimal accumulator: IDLE starts from zero, so a=d falls out of the same path.
  always_comb begin
    acc_base = '0;
    if (state == ENTER_A) acc_base = AW'(a);
    if (state == ENTER_B) acc_base = AW'(b);
    acc_new = acc_base * AW'(10) + AW'(key_code[3:0]);
    acc_ovf = |acc_new[AW-1:WIDTH];
  end

`ifdef CAL_BACKSPACE_EN
  localparam logic [4:0] KEY_BKSP = 5'h15;
  logic             is_bksp;
  logic [WIDTH-1:0] a_div;
  logic [WIDTH-1:0] b_div;

  assign is_bksp = (key_code == KEY_BKSP);
  assign a_div   = WIDTH'(AW'(a) / AW'(10));
  assign b_div   = WIDTH'(AW'(b) / AW'(10));
`endif

  always_ff @(posedge clk) begin
    err <= 1'b0;
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      op       <= 2'b00;
      op_valid <= 1'b0;
      bcnt     <= 4'd0;
    end else if (state == ISSUE) begin
      if (op_ready) begin
        state    <= IDLE;
        a        <= '0;
        b        <= '0;
        op       <= 2'b00;
        op_valid <= 1'b0;
        bcnt     <= 4'd0;
      end
    end else if (key_fire) begin
      case (state)
        IDLE: begin
          if (is_digit) begin
            if (acc_ovf) begin
              err <= 1'b1;
            end else begin
              a     <= acc_new[WIDTH-1:0];
              state <= ENTER_A;
            end
          end else if (is_opkey) begin
            a     <= '0;
            op    <= key_op;
            state <= ENTER_B;
          end
        end
        ENTER_A: begin
          if (is_digit) begin
            if (acc_ovf) err <= 1'b1;
            else         a   <= acc_new[WIDTH-1:0];
          end else if (is_opkey) begin
            op    <= key_op;
            state <= ENTER_B;
          end else if (is_clr) begin
            a     <= '0;
            b     <= '0;
            op    <= 2'b00;
            bcnt  <= 4'd0;
            state <= IDLE;
          end
`ifdef CAL_BACKSPACE_EN
          else if (is_bksp) begin
            a <= a_div;
            if (a_div == '0) state <= IDLE;
          end
`endif
        end
        ENTER_B: begin
          if (is_digit) begin
            if (acc_ovf) begin
              err <= 1'b1;
            end else begin
              b <= acc_new[WIDTH-1:0];
              if (bcnt != 4'hF) bcnt <= bcnt + 4'd1;
            end
          end else if (is_opkey) begin
            // Operator may only be changed before any B digit: no chaining.
            if (bcnt == 4'd0) op <= key_op;
          end else if (is_eq) begin
            if (bcnt != 4'd0) begin
              op_valid <= 1'b1;
              state    <= ISSUE;
            end
          end else if (is_clr) begin
            a     <= '0;
            b     <= '0;
            op    <= 2'b00;
            bcnt  <= 4'd0;
            state <= IDLE;
          end
`ifdef CAL_BACKSPACE_EN
          else if (is_bksp) begin
            if (bcnt != 4'd0) begin
              bcnt <= bcnt - 4'd1;
              b    <= (bcnt == 4'd1) ? '0 : b_div;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_entry_seq.sv
// tb/tb_cal_entry_seq.sv - directed self-checking bench for cal_entry_seq
// Exercises CAL_BACKSPACE_EN expectations when that macro is defined.
module tb_cal_entry_seq;

  localparam int WIDTH = 4;

  localparam logic [4:0] K_ADD  = 5'h10;
  localparam logic [4:0] K_SUB  = 5'h11;
  localparam logic [4:0] K_MUL  = 5'h12;
  localparam logic [4:0] K_EQ   = 5'h13;
  localparam logic [4:0] K_CLR  = 5'h14;
  localparam logic [4:0] K_BKSP = 5'h15;

  logic             clk;
  logic             rst;
  logic             key_valid;
  logic [4:0]       key_code;
  logic             key_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             op_valid;
  logic             op_ready;
  logic             err;

  int checks   = 0;
  int failures = 0;

  cal_entry_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one key for one edge, returns at the following negedge.
  task automatic key(input logic [4:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 5'd0;
    op_ready  = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_op", 32'(op), 0);
    chk("rst_op_valid", 32'(op_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_key_ready", 32'(key_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // 7 + 8 =, ALU stalls three cycles; a held digit key waits out ISSUE
    key(5'd7);
    chk("t2_a7", 32'(a), 7);
    key(K_ADD);
    chk("t2_op_add", 32'(op), 0);
    key(5'd8);
    chk("t2_b8", 32'(b), 8);
    key(K_EQ);
    key_valid = 1'b1;
    key_code  = 5'd3;
    for (int i = 0; i < 3; i++) begin
      chk("t2_valid_hold", 32'(op_valid), 1);
      chk("t2_ready_low", 32'(key_ready), 0);
      chk("t2_a_frozen", 32'(a), 7);
      chk("t2_b_frozen", 32'(b), 8);
      @(negedge clk);
    end
    chk("t2_valid_4th", 32'(op_valid), 1);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    chk("t2_valid_drop", 32'(op_valid), 0);
    chk("t2_a_clr", 32'(a), 0);
    chk("t2_b_clr", 32'(b), 0);
    chk("t2_ready_back", 32'(key_ready), 1);
    @(negedge clk);
    key_valid = 1'b0;
    chk("t2_held_key", 32'(a), 3);
    key(K_CLR);
    chk("t2_clr_a", 32'(a), 0);

    // Overflow of operand A
    key(5'd1);
    chk("t3_a1", 32'(a), 1);
    key(5'd5);
    chk("t3_a15", 32'(a), 15);
    chk("t3_no_err", 32'(err), 0);
    key(5'd2);
    chk("t3_a_kept", 32'(a), 15);
    chk("t3_err", 32'(err), 1);
    @(negedge clk);
    chk("t3_err_pulse", 32'(err), 0);
    key(5'h0A);
    chk("t3_bad_digit", 32'(a), 15);
    key(5'h17);
    chk("t3_bad_cmd", 32'(a), 15);
    key(K_CLR);

    // Operator replacement, early EQ ignored, no chaining, op_ready high on EQ edge
    key(5'd3);
    key(K_SUB);
    chk("t4_op_sub", 32'(op), 1);
    key(K_MUL);
    chk("t4_op_mul", 32'(op), 2);
    key(K_EQ);
    chk("t4_eq_ignored", 32'(op_valid), 0);
    key(5'd2);
    chk("t4_b2", 32'(b), 2);
    key(K_ADD);
    chk("t4_no_chain", 32'(op), 2);
    op_ready = 1'b1;
    key(K_EQ);
    chk("t4_issue_valid", 32'(op_valid), 1);
    chk("t4_issue_a", 32'(a), 3);
    chk("t4_issue_b", 32'(b), 2);
    chk("t4_issue_op", 32'(op), 2);
    @(negedge clk);
    op_ready = 1'b0;
    chk("t4_done_valid", 32'(op_valid), 0);
    chk("t4_done_op", 32'(op), 0);

    // Operator from IDLE, CLR, reset during ISSUE
    key(K_ADD);
    chk("t5_idle_op_a", 32'(a), 0);
    key(5'd5);
    chk("t5_idle_op_b", 32'(b), 5);
    key(K_CLR);
    key(5'd9);
    key(K_MUL);
    key(5'd4);
    key(K_CLR);
    chk("t5_clr_a", 32'(a), 0);
    chk("t5_clr_b", 32'(b), 0);
    chk("t5_clr_op", 32'(op), 0);
    key(5'd9);
    key(K_MUL);
    key(5'd4);
    key(K_EQ);
    chk("t5_issue", 32'(op_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_valid", 32'(op_valid), 0);
    chk("t5_rst_a", 32'(a), 0);
    chk("t5_rst_ready", 32'(key_ready), 1);

    // Backspace
    key(5'd1);
    key(5'd2);
    chk("t6_a12", 32'(a), 12);
    key(K_BKSP);
    key(5'd4);
`ifdef CAL_BACKSPACE_EN
    chk("t6_a14", 32'(a), 14);
    chk("t6_err", 32'(err), 0);
`else
    chk("t6_a12_kept", 32'(a), 12);
    chk("t6_err", 32'(err), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
